mdsa_top: RTL and testbench

- Hybrid multidimensional sorting array (MDSA) for 9 unsigned words held as a 3x3 matrix.
- Words are loaded serially. The block sorts them with alternating row and column 3-input sorter phases (shearsort schedule), then streams them out in ascending order.
- Top-level sorter block of the low-power sorter family; driven by a simple start/en/rdy handshake.

---
 rtl/mdsa_top.sv | 147 ++++++++++++++
 tb/tb_mdsa_top.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdsa_top.sv
// mdsa_top: 3x3 multidimensional sorting array.
// Nine words are loaded serially and sorted with five shearsort phases that
// alternate snake row sorts and column sorts. The result is then streamed out
// in ascending order by walking the matrix in snake order.
module mdsa_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rdy,
    output logic                  output_enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SORT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]            state;
    logic [3:0]            load_cnt;
    logic [2:0]            phase_cnt;
    logic [3:0]            out_cnt;
    logic [DATA_WIDTH-1:0] mat       [0:8];
    logic [DATA_WIDTH-1:0] phase_mat [0:8];
    logic [3*DATA_WIDTH-1:0] row_s   [0:2];
    logic [3*DATA_WIDTH-1:0] col_s   [0:2];
    logic [DATA_WIDTH-1:0] snake_word;

    // Three compare-exchange stages. The result is packed {hi, mid, lo}.
    function automatic logic [3*DATA_WIDTH-1:0] sort3(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] c
    );
        logic [DATA_WIDTH-1:0] x, y, z, t;
        x = a;
        y = b;
        z = c;
        t = '0;
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        return {z, y, x};
    endfunction

    // One 3-sorter per row and one per column. Both sets are always
    // evaluated; the phase counter selects which result is written back.
    // Phases 0, 2 and 4 are snake row sorts (row 1 is written descending).
    // Phases 1 and 3 are ascending column sorts.
    for (genvar r = 0; r < 3; r++) begin : g_row
        assign row_s[r] = sort3(mat[3*r], mat[3*r+1], mat[3*r+2]);
        assign col_s[r] = sort3(mat[r], mat[r+3], mat[r+6]);
        for (genvar c = 0; c < 3; c++) begin : g_col
            localparam int ROW_RANK = (r == 1) ? (2 - c) : c;
            assign phase_mat[3*r+c] = phase_cnt[0]
                ? col_s[c][r*DATA_WIDTH +: DATA_WIDTH]
                : row_s[r][ROW_RANK*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rdy = (state == IDLE) || (state == LOAD);

    // Select the next word to output by walking the matrix in snake order.
    always_comb begin
        snake_word = '0;
        case (out_cnt)
            4'd0:    snake_word = mat[0];
            4'd1:    snake_word = mat[1];
            4'd2:    snake_word = mat[2];
            4'd3:    snake_word = mat[5];
            4'd4:    snake_word = mat[4];
            4'd5:    snake_word = mat[3];
            4'd6:    snake_word = mat[6];
            4'd7:    snake_word = mat[7];
            4'd8:    snake_word = mat[8];
            default: snake_word = '0;
        endcase
    end

    // Frame control, matrix storage and the registered output stream.
    // The matrix changes only on load and sort-phase edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            load_cnt      <= '0;
            phase_cnt     <= '0;
            out_cnt       <= '0;
            output_enable <= 1'b0;
            data_out      <= '0;
            for (int i = 0; i < 9; i++) begin
                mat[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (en) begin
                        mat[load_cnt] <= data_in;
                        if (load_cnt == 4'd8) begin
                            state     <= SORT;
                            phase_cnt <= '0;
                            load_cnt  <= '0;
                        end else begin
                            load_cnt <= load_cnt + 4'd1;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < 9; i++) begin
                        mat[i] <= phase_mat[i];
                    end
                    if (phase_cnt == 3'd4) begin
                        state         <= OUT;
                        phase_cnt     <= '0;
                        output_enable <= 1'b1;
                        data_out      <= phase_mat[0];
                        out_cnt       <= 4'd1;
                    end else begin
                        phase_cnt <= phase_cnt + 3'd1;
                    end
                end
                OUT: begin
                    if (out_cnt == 4'd9) begin
                        state         <= IDLE;
                        output_enable <= 1'b0;
                        data_out      <= '0;
                        out_cnt       <= '0;
                    end else begin
                        data_out <= snake_word;
                        out_cnt  <= out_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdsa_top.sv
// tb_mdsa_top: drives whole frames into mdsa_top and compares the output stream
// against a plain sorted copy of the loaded words.
module tb_mdsa_top;

    typedef logic [7:0] frame_t [9];

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic [7:0] data_in;
    logic       rdy;
    logic       output_enable;
    logic [7:0] data_out;

    int     checks;
    int     errors;
    int     first_oe;
    int     n_oe;
    frame_t got;
    frame_t exp_s;
    frame_t w;
    bit     rdy_low_ok;
    logic   rdy_after;
    logic [7:0] dout_after;

    mdsa_top #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .en           (en),
        .data_in      (data_in),
        .rdy          (rdy),
        .output_enable(output_enable),
        .data_out     (data_out)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case something stalls the stimulus
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time expired, got stall expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: ascending multiset of the loaded words
    task automatic ref_sort(input frame_t in_w, output frame_t out_s);
        logic [7:0] t;
        out_s = in_w;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (out_s[j] > out_s[j+1]) begin
                    t = out_s[j];
                    out_s[j] = out_s[j+1];
                    out_s[j+1] = t;
                end
            end
        end
    endtask

    task automatic drive_cycle(input logic s, input logic e, input logic [7:0] d);
        @(negedge clk);
        start   = s;
        en      = e;
        data_in = d;
    endtask

    // gap_mode: 0 none, 1 a gap before every odd word, 2 random gaps
    task automatic load_words(input frame_t in_w, input int gap_mode, input int pre_hold);
        for (int i = 0; i < pre_hold; i++) drive_cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 9; i++) begin
            if (gap_mode == 1 && (i % 2) == 1) drive_cycle(1'b0, 1'b0, 8'($urandom));
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 1'b0, 8'($urandom));
            drive_cycle(1'b0, 1'b1, in_w[i]);
        end
    endtask

    // Sample at each negedge after the 9th load edge. Sample c reflects edge c
    // after that load edge. start is held for the first sort_hold edges and en
    // toggles randomly; both must be ignored.
    task automatic collect(input int sort_hold);
        bit done;
        done = 1'b0;
        first_oe = -1;
        n_oe = 0;
        rdy_low_ok = 1'b1;
        rdy_after = 1'bx;
        dout_after = 8'hxx;
        for (int i = 0; i < 9; i++) got[i] = 8'hxx;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (!done) begin
                if (output_enable === 1'b1) begin
                    if (first_oe < 0) first_oe = c;
                    if (n_oe < 9) got[n_oe] = data_out;
                end else if (first_oe >= 0) begin
                    done = 1'b1;
                    rdy_after = rdy;
                    dout_after = data_out;
                end
                if (!done && rdy !== 1'b0) rdy_low_ok = 1'b0;
            end
            if (output_enable === 1'b1) n_oe++;
            start   = (c + 1 <= sort_hold);
            en      = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
        end
        start = 1'b0;
        en    = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %b expected 1", rdy); end
        checks++; if (output_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", output_enable); end
        checks++; if (data_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_dout: got %0d expected 0", data_out); end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b0, 1'b1, 8'($urandom));
            if (output_enable !== 1'b0 || rdy !== 1'b1 || data_out !== 8'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_descending;
        w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_words(w, 0, 1);
        collect(0);
        checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL desc_latency: got %0d expected 5", first_oe); end
        checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL desc_oe_count: got %0d expected 9", n_oe); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("[TB] FAIL desc_word%0d: got %0d expected %0d", i, got[i], i + 1); end
        end
        checks++; if (rdy_low_ok !== 1'b1) begin errors++; $display("[TB] FAIL desc_rdy_busy: got rdy high expected low"); end
        checks++; if (rdy_after !== 1'b1) begin errors++; $display("[TB] FAIL desc_rdy_after: got %b expected 1", rdy_after); end
        checks++; if (dout_after !== 8'd0) begin errors++; $display("[TB] FAIL desc_dout_after: got %0d expected 0", dout_after); end
    endtask

    task automatic test_mixed_gaps;
        w = '{8'd200, 8'd3, 8'd3, 8'd255, 8'd0, 8'd17, 8'd128, 8'd3, 8'd64};
        ref_sort(w, exp_s);
        load_words(w, 1, 1);
        collect(0);
        checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL mixed_latency: got %0d expected 5", first_oe); end
        checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL mixed_oe_count: got %0d expected 9", n_oe); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== exp_s[i]) begin errors++; $display("[TB] FAIL mixed_word%0d: got %0d expected %0d", i, got[i], exp_s[i]); end
        end
        checks++; if (dout_after !== 8'd0) begin errors++; $display("[TB] FAIL mixed_dout_after: got %0d expected 0", dout_after); end
    endtask

    task automatic test_sorted_equal;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 9; i++) w[i] = (f == 0) ? 8'(i) : 8'hAA;
            ref_sort(w, exp_s);
            load_words(w, 0, 1);
            collect(0);
            checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL sorted%0d_latency: got %0d expected 5", f, first_oe); end
            checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL sorted%0d_oe_count: got %0d expected 9", f, n_oe); end
            for (int i = 0; i < 9; i++) begin
                checks++; if (got[i] !== exp_s[i]) begin errors++; $display("[TB] FAIL sorted%0d_word%0d: got %0d expected %0d", f, i, got[i], exp_s[i]); end
            end
        end
    endtask

    task automatic test_start_held;
        int extra;
        w = '{8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60};
        ref_sort(w, exp_s);
        load_words(w, 0, 4);
        collect(4);
        checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL held_latency: got %0d expected 5", first_oe); end
        checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL held_oe_count: got %0d expected 9", n_oe); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== exp_s[i]) begin errors++; $display("[TB] FAIL held_word%0d: got %0d expected %0d", i, got[i], exp_s[i]); end
        end
        checks++; if (rdy_low_ok !== 1'b1) begin errors++; $display("[TB] FAIL held_rdy_busy: got rdy high expected low"); end
        extra = 0;
        for (int c = 0; c < 25; c++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            if (output_enable !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL held_second_frame: got %0d oe cycles expected 0", extra); end
    endtask

    task automatic test_reset_abort;
        int extra;
        // Abort mid-LOAD
        drive_cycle(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 8'($urandom));
        @(negedge clk); start = 1'b0; en = 1'b0; rst = 1'b1; #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL abort_load_rdy: got %b expected 1", rdy); end
        @(negedge clk); rst = 1'b0;
        // Abort mid-SORT
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
        load_words(w, 0, 1);
        repeat (2) drive_cycle(1'b0, 1'b0, 8'd0);
        checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL abort_sort_busy: got %b expected 0", rdy); end
        rst = 1'b1; #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL abort_sort_rdy: got %b expected 1", rdy); end
        checks++; if (output_enable !== 1'b0) begin errors++; $display("[TB] FAIL abort_sort_oe: got %b expected 0", output_enable); end
        @(negedge clk); rst = 1'b0;
        // Abort mid-OUT
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(1, 255));
        load_words(w, 0, 1);
        repeat (8) drive_cycle(1'b0, 1'b0, 8'd0);
        checks++; if (output_enable !== 1'b1) begin errors++; $display("[TB] FAIL abort_out_active: got %b expected 1", output_enable); end
        rst = 1'b1; #1;
        checks++; if (output_enable !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_oe: got %b expected 0", output_enable); end
        checks++; if (data_out !== 8'd0) begin errors++; $display("[TB] FAIL abort_out_dout: got %0d expected 0", data_out); end
        @(negedge clk); rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, 1'b1, 8'($urandom));
            if (output_enable !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL abort_no_partial: got %0d oe cycles expected 0", extra); end
        // Normal frame after the aborts
        w = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd8, 8'd7, 8'd3, 8'd6, 8'd0};
        load_words(w, 0, 1);
        collect(0);
        checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL after_abort_latency: got %0d expected 5", first_oe); end
        checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL after_abort_oe_count: got %0d expected 9", n_oe); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("[TB] FAIL after_abort_word%0d: got %0d expected %0d", i, got[i], i); end
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 9; i++) w[i] = (f % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            ref_sort(w, exp_s);
            load_words(w, 2, 1 + (f % 3));
            collect(f % 4);
            checks++; if (first_oe !== 5) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 5", f, first_oe); end
            checks++; if (n_oe !== 9) begin errors++; $display("[TB] FAIL rand%0d_oe_count: got %0d expected 9", f, n_oe); end
            for (int i = 0; i < 9; i++) begin
                checks++; if (got[i] !== exp_s[i]) begin errors++; $display("[TB] FAIL rand%0d_word%0d: got %0d expected %0d", f, i, got[i], exp_s[i]); end
            end
            checks++; if (rdy_after !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_rdy_after: got %b expected 1", f, rdy_after); end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        en      = 1'b0;
        data_in = 8'd0;
        test_reset();
        test_descending();
        test_mixed_gaps();
        test_sorted_equal();
        test_start_held();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
